nibble_serial_add_sub: RTL and testbench

Sequential add/subtract controller that performs a wide two's-complement add or subtract one nibble per clock. It sits directly upstream of the team's 4-bit adder stage (full_adder_4b), driving its a/b/ci inputs and consuming its s/co outputs. Operands are accepted with a start/ready handshake. The result is presented with a one-cycle done pulse, plus carry and signed-overflow flags.

---
 rtl/nibble_serial_add_sub_pkg.sv | 14 +
 rtl/nibble_serial_add_sub_adder.sv | 21 ++
 rtl/nibble_serial_add_sub.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_add_sub.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_sub_pkg.sv
// Shared constants for the nibble-serial add/subtract controller:
// operation encodings and FSM state encodings.
package nibble_serial_add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_sub_adder.sv
// 4-bit adder stage with carry in and carry out. It is purely combinational
// and is used once per clock by the nibble-serial controller.
module full_adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] sum_full;

    // Add both operands and the incoming carry.
    // The top bit of the 5-bit sum is the carry out.
    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        s        = sum_full[3:0];
        co       = sum_full[4];
    end

endmodule

// File: rtl/nibble_serial_add_sub.sv
// Wide two's-complement add/subtract computed one nibble per clock through a
// single 4-bit adder. Operands are accepted with a start/ready handshake, and
// completion is signalled by a one-cycle done pulse with carry and overflow
// flags.
module nibble_serial_add_sub
    import nibble_serial_add_sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    // Operand registers are pure data. They are loaded only on the
    // accepting edge and are never reset.
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             op_q, op_d;

    logic [3:0]       add_a, add_b, add_s;
    logic             add_ci, add_co;
    logic             b_eff_msb;

    // Select the current nibble for the adder. In subtract mode, B is inverted
    // here; the +1 comes from the carry register, which is preset to op.
    always_comb begin
        add_a     = a_q[4*idx_q +: 4];
        add_b     = (op_q == OP_SUB) ? ~b_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
        add_ci    = carry_q;
        b_eff_msb = b_q[W-1] ^ op_q;
    end

    full_adder_4b u_adder (
        .a  ({add_a[3], add_a[2], add_a[1], add_a[0]}),
        .b  ({add_b[3], add_b[2], add_b[1], add_b[0]}),
        .ci (add_ci),
        .s  ({add_s[3], add_s[2], add_s[1], add_s[0]}),
        .co (add_co)
    );

    // Next-state logic: accept operands in IDLE, process one nibble per RUN
    // cycle, then spend one cycle in DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    a_d         = a;
                    b_d         = b;
                    op_d        = op;
                    idx_d       = '0;
                    carry_d     = op;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            S_RUN: begin
                result_d[4*idx_q +: 4] = add_s;
                carry_d                = add_co;
                idx_d                  = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    idx_d       = '0;
                    carry_out_d = add_co;
                    overflow_d  = (a_q[W-1] == b_eff_msb) && (add_s[3] != a_q[W-1]);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Operand registers (data only, not reset).
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    // Handshake outputs are decoded from state; the rest come from registers.
    always_comb begin
        ready     = (state_q == S_IDLE);
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        result    = result_q;
        carry_out = carry_out_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_nibble_serial_add_sub.sv
// Directed testbench for nibble_serial_add_sub with NIBBLES=4.
module tb_nibble_serial_add_sub;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;

    int n_cmp;
    int n_bad;

    nibble_serial_add_sub #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one operation and wait for done. Returns the number of cycles
    // from the start edge to the done cycle, the number of sampled cycles with
    // ready low, and a timeout flag. Operands are scrambled after the
    // accepting edge, so any late sampling shows up as a wrong result.
    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output int rdy_low, output logic tmo);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        a       = 16'hDEAD;
        b       = 16'hBEEF;
        op      = ~o;
        lat     = 0;
        rdy_low = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (ready === 1'b0) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
        tmo = (done !== 1'b1);
        if (ready === 1'b0) rdy_low++;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, done, carry_out, overflow} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=10000", {ready, busy, done, carry_out, overflow});
        end
        n_cmp++;
        if (result !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_result got=%h want=0000", result);
        end
    endtask

    task automatic test_add_basic();
        int lat, rl;
        logic tmo;
        do_op(1'b0, 16'h1234, 16'h0FFF, lat, rl, tmo);
        n_cmp++;
        if (tmo) begin
            n_bad++;
            $display("FAIL add_basic_timeout got=no_done want=done");
        end
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL add_basic_latency got=%0d want=4", lat);
        end
        n_cmp++;
        if ({result, carry_out, overflow} !== {16'h2233, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_basic_result got=%h c=%b v=%b want=2233 c=0 v=0", result, carry_out, overflow);
        end
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL add_basic_done_cycle got busy=%b ready=%b want busy=0 ready=0", busy, ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL add_basic_after got done=%b ready=%b want done=0 ready=1", done, ready);
        end
        n_cmp++;
        if (rl !== 5) begin
            n_bad++;
            $display("FAIL add_basic_ready_low got=%0d want=5", rl);
        end
        n_cmp++;
        if (result !== 16'h2233) begin
            n_bad++;
            $display("FAIL add_basic_hold got=%h want=2233", result);
        end
    endtask

    task automatic test_sub();
        int lat, rl;
        logic tmo;
        do_op(1'b1, 16'h0005, 16'h0007, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'hFFFE, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_borrow got=%h c=%b v=%b tmo=%b want=fffe c=0 v=0", result, carry_out, overflow, tmo);
        end
        do_op(1'b1, 16'h0007, 16'h0005, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'h0002, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_noborrow got=%h c=%b v=%b tmo=%b want=0002 c=1 v=0", result, carry_out, overflow, tmo);
        end
    endtask

    task automatic test_overflow();
        int lat, rl;
        logic tmo;
        do_op(1'b0, 16'h7FFF, 16'h0001, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'h8000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL add_ovf got=%h c=%b v=%b tmo=%b want=8000 c=0 v=1", result, carry_out, overflow, tmo);
        end
        do_op(1'b1, 16'h8000, 16'h0001, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_ovf got=%h c=%b v=%b tmo=%b want=7fff c=1 v=1", result, carry_out, overflow, tmo);
        end
    endtask

    task automatic test_full_ripple();
        int lat, rl;
        logic tmo;
        do_op(1'b0, 16'hFFFF, 16'h0001, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ripple got=%h c=%b v=%b tmo=%b want=0000 c=1 v=0", result, carry_out, overflow, tmo);
        end
    endtask

    task automatic test_start_ignored();
        int pulses;
        // The start edge is followed by the first RUN cycle.
        op    = 1'b0;
        a     = 16'h0001;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        // This is the second RUN cycle; this start request must be ignored.
        start = 1'b1;
        op    = 1'b1;
        a     = 16'hAAAA;
        @(posedge clk); #1;
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                pulses++;
                n_cmp++;
                if (result !== 16'h0002) begin
                    n_bad++;
                    $display("FAIL ignored_result got=%h want=0002", result);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL ignored_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses, lat, rl;
        logic tmo;
        op    = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, done, carry_out, overflow} !== 5'b10000 || result !== 16'h0000) begin
            n_bad++;
            $display("FAIL midrst_state got flags=%b res=%h want flags=10000 res=0000",
                     {ready, busy, done, carry_out, overflow}, result);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL midrst_nodone got=%0d want=0", pulses);
        end
        do_op(1'b0, 16'h00F0, 16'h0010, lat, rl, tmo);
        n_cmp++;
        if (tmo || lat !== 4 || {result, carry_out, overflow} !== {16'h0100, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_after got=%h c=%b v=%b lat=%0d want=0100 c=0 v=0 lat=4",
                     result, carry_out, overflow, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, rl;
        logic tmo;
        do_op(1'b0, 16'h4000, 16'h4000, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'h8000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_first got=%h c=%b v=%b want=8000 c=0 v=1", result, carry_out, overflow);
        end
        @(posedge clk); #1;
        do_op(1'b1, 16'h0000, 16'h0000, lat, rl, tmo);
        n_cmp++;
        if (tmo || {result, carry_out, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_second got=%h c=%b v=%b want=0000 c=1 v=0", result, carry_out, overflow);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add_basic();
        test_sub();
        test_overflow();
        test_full_ripple();
        @(posedge clk); #1;
        test_start_ignored();
        test_reset_mid_run();
        @(posedge clk); #1;
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
